f2_fetch_issue: RTL

- Receives the translated even/odd line addresses produced by the f1 TLB stage.
- Buffers them as fetch pairs in a small in-order queue.
- Issues each half independently to the even and odd I-cache banks over valid/ready handshakes.
- Back-pressures f1 with a stall when the queue is full, and converts TLB misses and exceptions into one-cycle notification pulses instead of bank requests.

---
 rtl/f_pkg.sv | 29 ++
 rtl/fetch_pair_fifo.sv | 72 +++++++
 rtl/f2_fetch_issue.sv | 137 +++++++++++++
 3 files changed

// File: rtl/f_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | f_pkg: shared types and defaults for the f2 fetch-issue stage.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package f_pkg;

  localparam int F_XLEN          = 32;
  localparam int F_SEQ_W         = 4;
  localparam int DEF_OFFSET_BITS = 4;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    MISS   = 2'd1,
    EXC    = 2'd2
  } fetch_kind_e;

  typedef struct packed {
    logic [F_XLEN-1:0]  addr_even;
    logic [F_XLEN-1:0]  addr_odd;
    logic               pcd;
    logic [F_SEQ_W-1:0] seq;
    fetch_kind_e        kind;
    logic               pend_even;
    logic               pend_odd;
  } fetch_pair_t;

endpackage
`default_nettype wire

// File: rtl/fetch_pair_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_pair_fifo: in-order circular buffer of fetch pairs.             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fetch_pair_fifo
  import f_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        push,
  input  fetch_pair_t push_data,
  input  logic        pop,
  input  logic        wb_en,
  input  logic        wb_pend_even,
  input  logic        wb_pend_odd,
  output fetch_pair_t head,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);

  fetch_pair_t   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Push targets the tail and write-back targets the head; they can only
  // alias when the buffer is empty or full, where one of them is blocked.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end else if (wb_en) begin
        mem_q[rd_ptr_q].pend_even <= wb_pend_even;
        mem_q[rd_ptr_q].pend_odd  <= wb_pend_odd;
      end
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/f2_fetch_issue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | f2_fetch_issue: queues translated line pairs and issues each half to  |
// | the even/odd I-cache banks; TLB misses/exceptions become pulses.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module f2_fetch_issue
  import f_pkg::*;
#(
  parameter int XLEN        = F_XLEN,
  parameter int DEPTH       = 2,
  parameter int OFFSET_BITS = DEF_OFFSET_BITS,
  parameter int SEQ_W       = F_SEQ_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             addr_even_valid,
  input  logic             addr_odd_valid,
  input  logic [XLEN-1:0]  addr_even,
  input  logic [XLEN-1:0]  addr_odd,
  input  logic             hit,
  input  logic             pcd,
  input  logic             exceptions,
  output logic             stall,
  output logic             ic_even_req_valid,
  input  logic             ic_even_req_ready,
  output logic [XLEN-1:0]  ic_even_req_addr,
  output logic             ic_even_req_pcd,
  output logic [SEQ_W-1:0] ic_even_req_seq,
  output logic             ic_odd_req_valid,
  input  logic             ic_odd_req_ready,
  output logic [XLEN-1:0]  ic_odd_req_addr,
  output logic             ic_odd_req_pcd,
  output logic [SEQ_W-1:0] ic_odd_req_seq,
  output logic             miss_valid,
  output logic             exc_valid,
  output logic [SEQ_W-1:0] miss_seq,
  output logic [SEQ_W-1:0] exc_seq
);

  localparam logic [XLEN-1:0] LINE_MASK = {XLEN{1'b1}} << OFFSET_BITS;

  logic [SEQ_W-1:0] seq_q;
  logic [SEQ_W-1:0] seq_d;
  fetch_pair_t      push_data;
  fetch_pair_t      head;
  fetch_kind_e      kind;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             head_valid;
  logic             head_normal;
  logic             hs_even;
  logic             hs_odd;
  logic             retire_normal;
  logic             wb_en;

  // No bypass: a full queue refuses capture even if the head retires now.
  assign stall = full;
  assign push  = (addr_even_valid | addr_odd_valid) & ~full & ~flush;
  assign seq_d = push ? seq_q + 1'b1 : seq_q;

  always_comb begin
    kind = NORMAL;
    if (exceptions) begin
      kind = EXC;
    end else if (!hit) begin
      kind = MISS;
    end
  end

  always_comb begin
    push_data           = '0;
    push_data.addr_even = addr_even;
    push_data.addr_odd  = addr_odd;
    push_data.pcd       = pcd;
    push_data.seq       = seq_q;
    push_data.kind      = kind;
    push_data.pend_even = (kind == NORMAL) & addr_even_valid;
    push_data.pend_odd  = (kind == NORMAL) & addr_odd_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seq_q <= '0;
    end else begin
      seq_q <= seq_d;
    end
  end

  fetch_pair_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .push         (push),
    .push_data    (push_data),
    .pop          (pop),
    .wb_en        (wb_en),
    .wb_pend_even (head.pend_even & ~hs_even),
    .wb_pend_odd  (head.pend_odd & ~hs_odd),
    .head         (head),
    .full         (full),
    .empty        (empty)
  );

  assign head_valid  = ~empty;
  assign head_normal = head_valid & (head.kind == NORMAL);

  assign ic_even_req_valid = head_normal & head.pend_even;
  assign ic_odd_req_valid  = head_normal & head.pend_odd;
  assign hs_even           = ic_even_req_valid & ic_even_req_ready;
  assign hs_odd            = ic_odd_req_valid & ic_odd_req_ready;

  assign ic_even_req_addr = ic_even_req_valid ? (head.addr_even & LINE_MASK) : '0;
  assign ic_odd_req_addr  = ic_odd_req_valid  ? (head.addr_odd  & LINE_MASK) : '0;
  assign ic_even_req_pcd  = ic_even_req_valid & head.pcd;
  assign ic_odd_req_pcd   = ic_odd_req_valid  & head.pcd;
  assign ic_even_req_seq  = ic_even_req_valid ? head.seq : '0;
  assign ic_odd_req_seq   = ic_odd_req_valid  ? head.seq : '0;

  assign miss_valid = head_valid & (head.kind == MISS);
  assign exc_valid  = head_valid & (head.kind == EXC);
  assign miss_seq   = miss_valid ? head.seq : '0;
  assign exc_seq    = exc_valid  ? head.seq : '0;

  // A NORMAL head leaves once every outstanding half has handshaken.
  assign retire_normal = head_normal & (~head.pend_even | hs_even)
                                     & (~head.pend_odd  | hs_odd);
  assign pop   = (retire_normal | miss_valid | exc_valid) & ~flush;
  assign wb_en = (hs_even | hs_odd) & ~pop;

endmodule
`default_nettype wire
